// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU function codes, status bit positions, op codes and FSM states
package alu_sequencer_pkg;

    localparam int REG_WIDTH = 8;
    localparam int OPP_WIDTH = 3;

    // ALU function select codes
    localparam logic [OPP_WIDTH-1:0] SUM    = 3'd0;
    localparam logic [OPP_WIDTH-1:0] AND    = 3'd1;
    localparam logic [OPP_WIDTH-1:0] OR     = 3'd2;
    localparam logic [OPP_WIDTH-1:0] XOR    = 3'd3;
    localparam logic [OPP_WIDTH-1:0] SR     = 3'd4;
    localparam logic [OPP_WIDTH-1:0] NO_OPP = 3'd7;

    // 6502 status register bit positions
    localparam int CARRY      = 0;
    localparam int ZERO       = 1;
    localparam int V_OVERFLOW = 6;
    localparam int NEG        = 7;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_ASL = 4'd5,
        OP_LSR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8,
        OP_INC = 4'd9,
        OP_DEC = 4'd10,
        OP_CMP = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/response interface and ALU operand/function interface
// alu_req_if: execute unit (master) <-> sequencer (slave); req_* valid/ready in, rsp_* valid/ready out.
// alu_bus_if: sequencer (master) drives operands/func/carry/invert, ALU (slave) returns dout/status/wout.
interface alu_req_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [OP_W-1:0]  req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_m;
    logic [WIDTH-1:0] req_p;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_p;
    logic             rsp_wb;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_m, req_p, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_p, rsp_wb, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_m, req_p, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_p, rsp_wb, rsp_err
    );
endinterface

interface alu_bus_if
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
);
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [OPP_WIDTH-1:0] alu_func;
    logic [WIDTH-1:0]     alu_status;
    logic                 alu_carry;
    logic                 alu_dec;
    logic                 alu_invert;
    logic [WIDTH-1:0]     alu_dout;
    logic [WIDTH-1:0]     alu_status_in;
    logic                 alu_wout;

    modport master (
        output alu_a, alu_b, alu_func, alu_status, alu_carry, alu_dec, alu_invert,
        input  alu_dout, alu_status_in, alu_wout
    );

    modport slave (
        input  alu_a, alu_b, alu_func, alu_status, alu_carry, alu_dec, alu_invert,
        output alu_dout, alu_status_in, alu_wout
    );
endinterface

// File: rtl/alu_sequencer_flag_merge.sv
// rtl/alu_sequencer_flag_merge.sv - combinational N/Z/C/V merge of an ALU result into P
// Ports: op (micro-op), a_msb/m_msb (operand sign bits), res (ALU result),
//        alu_c (ALU carry out), p_in (status at request), p_out (merged status).
module alu_flag_merge
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int OP_W  = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic             a_msb,
    input  logic             m_msb,
    input  logic [WIDTH-1:0] res,
    input  logic             alu_c,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] p_out
);
    logic res_msb;

    assign res_msb = res[WIDTH-1];

    always_comb begin
        p_out = p_in;
        if (op_legal(op)) begin
            p_out[NEG]  = res_msb;
            p_out[ZERO] = (res == '0);
        end
        case (op)
            OP_ADC: begin
                p_out[CARRY]      = alu_c;
                p_out[V_OVERFLOW] = (a_msb == m_msb) && (res_msb != a_msb);
            end
            OP_SBC: begin
                // The ALU reports borrow when inverting; 6502 C means no borrow.
                p_out[CARRY]      = ~alu_c;
                p_out[V_OVERFLOW] = (a_msb == ~m_msb) && (res_msb != a_msb);
            end
            OP_CMP:                         p_out[CARRY] = ~alu_c;
            OP_ASL, OP_ROL, OP_LSR, OP_ROR: p_out[CARRY] = alu_c;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues 6502 ALU micro-ops to the ALU and returns result plus merged status
// Ports: phi1 clock, reset_n async active-low reset, req (alu_req_if.slave) for request/response,
//        alu (alu_bus_if.master) toward the ALU. Optional macro ALU_TIMEOUT_EN adds a WAIT timeout.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH          = REG_WIDTH,
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic      phi1,
    input  logic      reset_n,
    alu_req_if.slave  req,
    alu_bus_if.master alu
);
    state_t               state;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_wb_q;
    logic                 rsp_err_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic [WIDTH-1:0]     rsp_p_q;
    logic [WIDTH-1:0]     p_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [OPP_WIDTH-1:0] func_q;
    logic                 carry_q;
    logic                 invert_q;
    logic [OP_W-1:0]      op_q;
    logic                 m_msb_q;

    logic [OPP_WIDTH-1:0] set_func;
    logic [WIDTH-1:0]     set_b;
    logic                 set_carry;
    logic                 set_invert;
    logic [WIDTH-1:0]     p_merged;

`ifdef ALU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt;
`endif

    assign req.req_ready  = req_ready_q;
    assign req.rsp_valid  = rsp_valid_q;
    assign req.rsp_data   = rsp_data_q;
    assign req.rsp_p      = rsp_p_q;
    assign req.rsp_wb     = rsp_wb_q;
    assign req.rsp_err    = rsp_err_q;
    assign alu.alu_a      = alu_a_q;
    assign alu.alu_b      = alu_b_q;
    assign alu.alu_func   = func_q;
    assign alu.alu_status = p_q;
    assign alu.alu_carry  = carry_q;
    assign alu.alu_dec    = 1'b0;
    assign alu.alu_invert = invert_q;

    // ALU setup for the incoming op; alu_a is always the A operand.
    // With invert set the ALU complements both b and carry-in, so SBC passes ~C.
    always_comb begin
        set_func   = SUM;
        set_b      = req.req_m;
        set_carry  = 1'b0;
        set_invert = 1'b0;
        case (req.req_op)
            OP_ADC: set_carry = req.req_p[CARRY];
            OP_SBC: begin
                set_carry  = ~req.req_p[CARRY];
                set_invert = 1'b1;
            end
            OP_CMP: set_invert = 1'b1;
            OP_AND: set_func = AND;
            OP_ORA: set_func = OR;
            OP_EOR: set_func = XOR;
            OP_ASL: set_b = req.req_a;
            OP_ROL: begin
                set_b     = req.req_a;
                set_carry = req.req_p[CARRY];
            end
            OP_LSR: begin
                set_func = SR;
                set_b    = '0;
            end
            OP_ROR: begin
                set_func  = SR;
                set_b     = '0;
                set_carry = req.req_p[CARRY];
            end
            OP_INC: begin
                set_b     = '0;
                set_carry = 1'b1;
            end
            OP_DEC: begin
                set_b      = '0;
                set_carry  = 1'b1;
                set_invert = 1'b1;
            end
            default: ;
        endcase
    end

    alu_flag_merge #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_flag_merge (
        .op    (op_q),
        .a_msb (alu_a_q[WIDTH-1]),
        .m_msb (m_msb_q),
        .res   (alu.alu_dout),
        .alu_c (alu.alu_status_in[CARRY]),
        .p_in  (p_q),
        .p_out (p_merged)
    );

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_wb_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_p_q     <= '0;
            p_q         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            func_q      <= NO_OPP;
            carry_q     <= 1'b0;
            invert_q    <= 1'b0;
            op_q        <= '0;
            m_msb_q     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        req_ready_q <= 1'b0;
                        op_q        <= req.req_op;
                        p_q         <= req.req_p;
                        alu_a_q     <= req.req_a;
                        m_msb_q     <= req.req_m[WIDTH-1];
                        if (op_legal(req.req_op)) begin
                            alu_b_q  <= set_b;
                            func_q   <= set_func;
                            carry_q  <= set_carry;
                            invert_q <= set_invert;
                            state    <= ST_WAIT;
`ifdef ALU_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= req.req_a;
                            rsp_p_q     <= req.req_p;
                            rsp_err_q   <= 1'b1;
                            rsp_wb_q    <= 1'b0;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (alu.alu_wout) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= alu.alu_dout;
                        rsp_p_q     <= p_merged;
                        rsp_err_q   <= 1'b0;
                        rsp_wb_q    <= (op_q != OP_CMP);
                        // Dropping to NO_OPP lets an identical next func re-strobe.
                        func_q      <= NO_OPP;
                        state       <= ST_RESP;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= alu_a_q;
                        rsp_p_q     <= p_q;
                        rsp_err_q   <= 1'b1;
                        rsp_wb_q    <= 1'b0;
                        func_q      <= NO_OPP;
                        state       <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (req.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
